// File: rtl/seg_display_formatter.sv
// seg_display_formatter: turns a 16-bit binary value into four active-low
// seven-segment patterns ({dp,g,f,e,d,c,b,a}), either as hex nibbles or as
// decimal digits produced by a 16-step iterative double-dabble conversion.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for load; captures value and display options
// CONVERT | one double-dabble step per cycle, 16 steps in total
// ENCODE  | single cycle: register segs/overflow, pulse done, back to IDLE
module seg_display_formatter (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     value,
    input  logic            load,
    input  logic            mode,
    input  logic            blank_lz,
    input  logic [3:0]      dp_mask,
    output logic [3:0][7:0] segs,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        ENCODE  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    state_t         state;
    state_t         state_nxt;

    logic           mode_q;
    logic           blank_q;
    logic [3:0]     dp_q;
    logic [19:0]    bcd;
    logic [15:0]    shift_reg;
    logic [3:0]     step;

    logic [19:0]    bcd_adj;
    logic [3:0][7:0] segs_enc;
    logic           ovf_enc;
    logic           load_ok;
    logic           last_step;

    // Glyph lookup for one nibble (hex digits double as decimal digits 0-9).
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign load_ok   = (state == IDLE) && load;
    assign last_step = (step == 4'd15);
    assign busy      = (state != IDLE);

    // Per-digit add-3 correction applied before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment encoding of the current digit register: overflow dashes,
    // leading-zero blanking from the top down, then decimal points on top.
    always_comb begin
        logic z3;
        logic z2;
        logic z1;
        segs_enc = '{default: SEG_BLANK};
        ovf_enc  = mode_q && (bcd[19:16] != 4'd0);
        z3 = (bcd[15:12] == 4'd0);
        z2 = z3 && (bcd[11:8] == 4'd0);
        z1 = z2 && (bcd[7:4] == 4'd0);
        if (ovf_enc) begin
            for (int i = 0; i < 4; i++) begin
                segs_enc[i] = SEG_DASH;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                segs_enc[i] = glyph(bcd[4*i +: 4]);
            end
            if (blank_q) begin
                if (z3) segs_enc[3] = SEG_BLANK;
                if (z2) segs_enc[2] = SEG_BLANK;
                if (z1) segs_enc[1] = SEG_BLANK;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (dp_q[i]) begin
                segs_enc[i][7] = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = mode ? CONVERT : ENCODE;
                end
            end
            CONVERT: begin
                if (last_step) begin
                    state_nxt = ENCODE;
                end
            end
            ENCODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture of options and the digit/shift datapath. In hex mode the
    // nibbles go straight into the low 16 bits of the digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            blank_q   <= 1'b0;
            dp_q      <= 4'd0;
            bcd       <= 20'd0;
            shift_reg <= 16'd0;
            step      <= 4'd0;
        end else if (load_ok) begin
            mode_q  <= mode;
            blank_q <= blank_lz;
            dp_q    <= dp_mask;
            step    <= 4'd0;
            if (mode) begin
                bcd       <= 20'd0;
                shift_reg <= value;
            end else begin
                bcd       <= {4'd0, value};
                shift_reg <= 16'd0;
            end
        end else if (state == CONVERT) begin
            {bcd, shift_reg} <= {bcd_adj[18:0], shift_reg, 1'b0};
            step             <= step + 4'd1;
        end
    end

    // Output registers: updated only in ENCODE, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segs     <= '{default: SEG_BLANK};
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == ENCODE);
            if (state == ENCODE) begin
                segs     <= segs_enc;
                overflow <= ovf_enc;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_formatter.sv
// tb_seg_display_formatter: directed vectors with hand-computed segment
// patterns, latencies and done-pulse counts for seg_display_formatter.
module tb_seg_display_formatter;

    logic            clk;
    logic            rst_n;
    logic [15:0]     value;
    logic            load;
    logic            mode;
    logic            blank_lz;
    logic [3:0]      dp_mask;
    logic [3:0][7:0] segs;
    logic            busy;
    logic            done;
    logic            overflow;

    int n_cmp = 0;
    int n_bad = 0;

    seg_display_formatter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .segs     (segs),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Drive a load for one edge; returns at #1 after the accepting edge T.
    task automatic start_conv(input logic [15:0] v, input logic m, input logic bl,
                              input logic [3:0] dp);
        value    = v;
        mode     = m;
        blank_lz = bl;
        dp_mask  = dp;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Wait for done (bounded); lat = edges elapsed since the caller's edge.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Count done pulses over n cycles.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    task automatic conv(input string tag, input logic [15:0] v, input logic m,
                        input logic bl, input logic [3:0] dp,
                        input logic [31:0] exp_segs, input logic exp_ovf);
        int lat;
        start_conv(v, m, bl, dp);
        chk({tag, "_busy_T"}, {31'd0, busy}, 32'd1);
        wait_done(tag, lat);
        chk({tag, "_lat"}, lat, m ? 32'd17 : 32'd1);
        chk({tag, "_segs"}, segs, exp_segs);
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic idle2();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int cnt;
        rst_n    = 1'b0;
        value    = 16'd0;
        load     = 1'b0;
        mode     = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_segs", segs, 32'hFFFF_FFFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        conv("hex_beef", 16'hBEEF, 1'b0, 1'b0, 4'h0, 32'h8386_868E, 1'b0);
        idle2();
        conv("dec_1234", 16'd1234, 1'b1, 1'b0, 4'h0, 32'hF9A4_B099, 1'b0);
        idle2();
        conv("dec_42_lz", 16'd42, 1'b1, 1'b1, 4'h0, 32'hFFFF_99A4, 1'b0);
        idle2();
        conv("dec_0_lz", 16'd0, 1'b1, 1'b1, 4'h0, 32'hFFFF_FFC0, 1'b0);
        idle2();
        conv("dec_1005_lz", 16'd1005, 1'b1, 1'b1, 4'h0, 32'hF9C0_C092, 1'b0);
        idle2();
        conv("hex_0001_lz_dp", 16'h0001, 1'b0, 1'b1, 4'b0100, 32'hFF7F_FFF9, 1'b0);
        idle2();
        conv("dec_65535", 16'd65535, 1'b1, 1'b0, 4'h0, 32'hBFBF_BFBF, 1'b1);
        idle2();

        // load while busy is ignored
        start_conv(16'd1234, 1'b1, 1'b0, 4'h0);
        repeat (4) @(posedge clk);
        #1;
        start_conv(16'd9999, 1'b1, 1'b1, 4'hF);
        wait_done("ign", lat);
        chk("ign_lat", lat, 32'd12);
        chk("ign_segs", segs, 32'hF9A4_B099);
        count_done(25, cnt);
        chk("ign_done_once", cnt, 32'd0);
        chk("ign_segs_hold", segs, 32'hF9A4_B099);

        // back-to-back: second load placed in the done cycle
        conv("b2b_first", 16'd9999, 1'b1, 1'b0, 4'h0, 32'h9090_9090, 1'b0);
        conv("b2b_second", 16'd7, 1'b1, 1'b0, 4'h0, 32'hC0C0_C0F8, 1'b0);
        idle2();

        // overflow with dp on digit 0, then abort a conversion at step 8
        conv("dec_12345_dp", 16'd12345, 1'b1, 1'b0, 4'b0001, 32'hBFBF_BF3F, 1'b1);
        idle2();
        start_conv(16'd1234, 1'b1, 1'b0, 4'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_segs", segs, 32'hFFFF_FFFF);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(25, cnt);
        chk("abort_no_done", cnt, 32'd0);
        chk("abort_segs_after", segs, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
